fnd_frame_sender: RTL and testbench

Upstream command stage of the SPI-to-FND path. Debounces the push button, samples the 14-bit switch value, clamps it to the 4-digit display range, and serialises it as a two-byte frame (high byte, then low byte) through the SPI master's `start`/`ready`/`done` handshake. An optional auto-repeat mode resends the current switch value periodically. The downstream slave FSM rebuilds the 14-bit value for the FND controller.

---
 rtl/fnd_frame_sender_if.sv | 10 +
 rtl/fnd_frame_sender.sv | 140 ++++++++++++++
 tb/tb_fnd_frame_sender.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_frame_sender_if.sv
// rtl/fnd_frame_sender_if.sv - byte handshake between the frame sender and the SPI master
interface fnd_frame_sender_if;
  logic       start;
  logic       ready;
  logic       done;
  logic [7:0] data;

  modport master (output start, output data, input ready, input done);
  modport slave  (input start, input data, output ready, output done);
endinterface

// File: rtl/fnd_frame_sender.sv
// rtl/fnd_frame_sender.sv - debounced button / auto-repeat trigger that sends a clamped 14-bit
// switch value to the SPI master as a two-byte frame {2'b10, val[13:8]}, val[7:0]
module fnd_frame_sender #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int AUTO_PERIOD     = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic [14:0]        sw,
  output logic               busy,
  fnd_frame_sender_if.master spi
);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
  localparam logic [13:0]       VAL_MAX   = 14'd9999;

  typedef enum logic [2:0] {IDLE, LOAD_HI, WAIT_HI, LOAD_LO, WAIT_LO} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                level_q, level_d;
  logic                level_prev_q, level_prev_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
  logic [7:0]          val_lo_q, val_lo_d;
  logic [7:0]          data_q, data_d;
  logic                start_q, start_d;

  logic                btn_trig;
  logic                auto_trig;
  logic [13:0]         val_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      deb_cnt_q    <= '0;
      auto_cnt_q   <= '0;
      val_lo_q     <= '0;
      data_q       <= '0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      deb_cnt_q    <= deb_cnt_d;
      auto_cnt_q   <= auto_cnt_d;
      val_lo_q     <= val_lo_d;
      data_q       <= data_d;
      start_q      <= start_d;
    end
  end

  // Debouncer: any cycle where the synchronised level agrees with the accepted one restarts the count.
  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    level_d      = level_q;
    deb_cnt_d    = '0;
    level_prev_d = level_q;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign btn_trig = level_q & ~level_prev_q;
  assign val_in   = (sw[13:0] > VAL_MAX) ? VAL_MAX : sw[13:0];

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    data_d     = data_q;
    val_lo_d   = val_lo_q;
    auto_trig  = 1'b0;
    auto_cnt_d = auto_cnt_q;

    if (!sw[14]) begin
      auto_cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (auto_cnt_q == AUTO_LAST) begin
        auto_trig = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + AUTO_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        // Both triggers in one cycle collapse into a single frame.
        if (btn_trig || auto_trig) begin
          val_lo_d = val_in[7:0];
          data_d   = {2'b10, val_in[13:8]};
          state_d  = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (spi.ready) begin
          start_d = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (spi.done) begin
          data_d  = val_lo_q;
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (spi.ready) begin
          start_d = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (spi.done) begin
          auto_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi.start = start_q;
  assign spi.data  = data_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fnd_frame_sender.sv
// tb/tb_fnd_frame_sender.sv - directed bench for fnd_frame_sender with an SPI master model and byte scoreboard
module tb_fnd_frame_sender;
  localparam int DEB  = 50;
  localparam int AUTO = 200;
  localparam int XFER = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn = 1'b0;
  logic [14:0] sw  = '0;
  logic        busy;

  fnd_frame_sender_if spi_if();

  fnd_frame_sender #(.DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(AUTO)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .busy (busy),
    .spi  (spi_if)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         start_cnt = 0;
  int         xfer_left = 0;
  int         cyc = 0;
  int         last_done_cyc = 0;
  bit         hold_ready = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] clamp(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
  endtask

  task automatic push_frame(input logic [13:0] v);
    logic [13:0] c;
    c = clamp(v);
    push_bytes({2'b10, c[13:8]}, c[7:0]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string tag, output int n);
    n = 0;
    while (busy !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'(lvl));
  endtask

  task automatic wait_starts(input int target, input int limit, input string tag);
    int n;
    n = 0;
    while (start_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, start_cnt, target);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: done arrives XFER cycles after each start; ready is low while a byte is in flight.
  initial begin
    spi_if.ready = 1'b1;
    spi_if.done  = 1'b0;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    spi_if.done = 1'b0;
    if (xfer_left > 0) begin
      xfer_left--;
      if (xfer_left == 0) begin
        spi_if.done   = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (spi_if.start === 1'b1) begin
      start_cnt++;
      check("start_while_ready", 32'(spi_if.ready), 1);
      check("byte_expected_at_start", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("byte_value", 32'(spi_if.data), 32'(e));
      end
      xfer_left = XFER;
    end
    spi_if.ready = (xfer_left == 0) && !hold_ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    int s1;

    cycles(3);
    check("reset_start", 32'(spi_if.start), 0);
    check("reset_data", 32'(spi_if.data), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b1;
    cycles(5);

    // Clean press of 1234
    sw = 15'h04D2;
    push_bytes(8'h84, 8'hD2);
    s0 = start_cnt;
    btn = 1'b1;
    wait_busy(1'b1, 300, "t1_busy_rise", n);
    check("t1_busy_latency", n, DEB + 3);
    @(negedge clk);
    check("t1_first_start", 32'(spi_if.start), 1);
    btn = 1'b0;
    wait_busy(1'b0, 300, "t1_busy_fall", n);
    check("t1_busy_fall_after_done", cyc - last_done_cyc, 1);
    check("t1_start_count", start_cnt - s0, 2);
    check("t1_queue_empty", exp_q.size(), 0);
    cycles(80);

    // Clamp to 9999
    sw = 15'h3FFF;
    push_bytes(8'hA7, 8'h0F);
    s0 = start_cnt;
    btn = 1'b1;
    wait_busy(1'b1, 300, "t2_busy_rise", n);
    btn = 1'b0;
    wait_busy(1'b0, 300, "t2_busy_fall", n);
    check("t2_start_count", start_cnt - s0, 2);
    cycles(80);

    // Bouncing button
    sw = 15'd42;
    push_frame(14'd42);
    s0 = start_cnt;
    for (int i = 0; i < 50; i++) begin
      btn = ~btn;
      cycles(10);
    end
    check("t3_no_frame_while_bouncing", start_cnt - s0, 0);
    btn = 1'b1;
    wait_busy(1'b1, 300, "t3_busy_rise", n);
    btn = 1'b0;
    wait_busy(1'b0, 300, "t3_busy_fall", n);
    cycles(100);
    check("t3_start_count", start_cnt - s0, 2);

    // Second press while busy, ready held low after byte 0
    sw = 15'd500;
    push_frame(14'd500);
    s0 = start_cnt;
    btn = 1'b1;
    wait_starts(s0 + 1, 300, "t4_first_start");
    hold_ready = 1'b1;
    btn = 1'b0;
    cycles(55);
    btn = 1'b1;
    cycles(45);
    check("t4_no_start_while_not_ready", start_cnt - s0, 1);
    check("t4_busy_held", 32'(busy), 1);
    hold_ready = 1'b0;
    wait_busy(1'b0, 300, "t4_busy_fall", n);
    btn = 1'b0;
    cycles(200);
    check("t4_second_press_dropped", start_cnt - s0, 2);
    check("t4_queue_empty", exp_q.size(), 0);

    // Auto-repeat
    s0 = start_cnt;
    sw = {1'b1, 14'd100};
    push_frame(14'd100);
    wait_busy(1'b1, 400, "t5_first_auto", n);
    check("t5_first_auto_delay", n, AUTO);
    wait_busy(1'b0, 300, "t5_f1_done", n);
    sw = {1'b1, 14'd9000};
    push_frame(14'd9000);
    wait_busy(1'b1, 400, "t5_f2_rise", n);
    check("t5_spacing", n, AUTO);
    wait_busy(1'b0, 300, "t5_f2_done", n);
    sw = {1'b1, 14'd12000};
    push_frame(14'd12000);
    wait_busy(1'b1, 400, "t5_f3_rise", n);
    s1 = start_cnt;
    wait_starts(s1 + 1, 100, "t5_f3_first_start");
    sw = {1'b0, 14'd12000};
    wait_busy(1'b0, 300, "t5_f3_done", n);
    cycles(500);
    check("t5_start_count", start_cnt - s0, 6);
    check("t5_queue_empty", exp_q.size(), 0);

    // Reset during WAIT_HI
    sw = 15'h04D2;
    push_bytes(8'h84, 8'hD2);
    s0 = start_cnt;
    btn = 1'b1;
    wait_starts(s0 + 1, 300, "t6_first_start");
    btn = 1'b0;
    cycles(5);
    rst = 1'b0;
    @(negedge clk);
    check("t6_reset_start", 32'(spi_if.start), 0);
    check("t6_reset_busy", 32'(busy), 0);
    check("t6_reset_data", 32'(spi_if.data), 0);
    cycles(1);
    rst = 1'b1;
    exp_q.delete();
    cycles(100);
    check("t6_no_byte1_after_reset", start_cnt - s0, 1);
    check("t6_idle_after_late_done", 32'(busy), 0);
    s0 = start_cnt;
    push_bytes(8'h84, 8'hD2);
    btn = 1'b1;
    wait_busy(1'b1, 300, "t6_busy_rise", n);
    btn = 1'b0;
    wait_busy(1'b0, 300, "t6_busy_fall", n);
    check("t6_full_frame", start_cnt - s0, 2);
    check("t6_queue_empty", exp_q.size(), 0);
    cycles(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
